fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Sequences instruction fetch for the SEQ core. Owns the PC register, drives the
//   combinational instruction memory address, and captures {pc, instruction} into a
//   small fetch queue. Decode consumes from that queue over a valid/ready handshake.
//   Branch/jump redirects from execute flush the queue and reload the PC.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded on reset
//   QUEUE_DEPTH 2              fetch queue entries; power of two, >= 2
// PORTS
//   clk             in   1   system clock, rising edge
//   reset           in   1   asynchronous reset, active-high
//   fetch_en        in   1   1 = fetch may advance; 0 = hold PC, queue drains
//   imem_addr       out  32  byte address to instruction memory (= PC register)
//   imem_instr      in   32  instruction word returned combinationally for imem_addr
//   redirect_valid  in   1   1-cycle pulse: load PC from redirect_pc, flush queue
//   redirect_pc     in   32  redirect target byte address
//   out_valid       out  1   head of fetch queue is valid
//   out_ready       in   1   decode accepts the head entry this cycle
//   out_pc          out  32  PC of head entry
//   out_instr       out  32  instruction of head entry
//   fault_misalign  out  1   sticky: a redirect target had redirect_pc[1:0] != 0
//   fetch_count     out  32  count of words pushed into the queue; wraps mod 2^32
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, state=IDLE, queue count=0, out_valid=0,
//     out_pc=0, out_instr=0, fault_misalign=0, fetch_count=0. No clock edge needed.
//   State machine: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0.
//     Queue contents are kept across RUN->IDLE; only pushes stop.
//   imem_addr = pc at all times (combinational from the PC register).
//   pop  = out_valid & out_ready.
//   push = (state==RUN) & ~redirect_valid & (count<QUEUE_DEPTH | pop).
//     Push writes {pc, imem_instr} at the tail, then pc <= pc+4 and fetch_count += 1.
//     A push and a pop in the same cycle on a full queue are both performed.
//   PC arithmetic is 32-bit: 32'hFFFF_FFFC + 4 wraps to 0. No fault is raised.
//   Latency: a word addressed in cycle N appears on out_* in cycle N+1 when the
//     queue was empty. Sustained throughput is 1 word/cycle with out_ready=1.
//   Queue is first-word fall-through: out_valid = (count!=0); out_pc/out_instr
//     show the head entry, and are held stable while out_valid=1 & out_ready=0.
//   out_pc/out_instr are don't-care when out_valid=0, except after reset (0).
//   Redirect has the highest priority:
//     count <= 0 and pc <= {redirect_pc[31:2],2'b00}.
//     No push occurs in that cycle; any pop in that cycle is absorbed by the flush.
//     If redirect_pc[1:0]!=0, fault_misalign <= 1. It stays set until reset.
//   Redirect is honoured in IDLE as well (PC and queue update; state unchanged).
//   fetch_en=1 with a redirect in the same cycle: state goes to RUN, and fetching
//     starts from the new PC in the next cycle.
// TESTING
//   1. Release reset, memory word k = 32'h1000+k, fetch_en=1, out_ready=1 ->
//      out_pc = 0,4,8,... on consecutive cycles with out_instr 1000,1001,1002; fetch_count increments each cycle.
//   2. out_ready=0 from start -> two pushes, then out_valid=1, imem_addr holds 8,
//      head stays pc 0. Then out_ready=1 -> pcs 0,4,8,12 in order, none lost or duplicated.
//   3. Queue full (pc 0,4), redirect_valid=1, redirect_pc=0x40 -> next cycle
//      out_valid=0 and imem_addr=0x40; the cycle after, out_pc=0x40.
//   4. redirect_pc=0x42 -> imem_addr=0x40, fault_misalign=1; it stays 1 after
//      later aligned redirects until reset.
//   5. fetch_en dropped with 2 entries queued, out_ready=1 -> 2 entries drain,
//      imem_addr frozen, fetch_count frozen. Reassert fetch_en -> fetch resumes at the frozen PC.
//   6. Assert reset between clock edges mid-run -> out_valid=0, imem_addr=RESET_PC,
//      fetch_count=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences instruction fetch for the SEQ core. Holds the PC register, presents it
//   as the instruction memory address, and captures {pc, instruction} pairs into a
//   small first-word fall-through queue that decode drains over valid/ready.
//   A redirect from execute flushes the queue and reloads the PC.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   QUEUE_DEPTH  fetch queue entries (power of two, >= 2)
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous reset, active-high
//   fetch_en        1 = fetch may advance; 0 = PC holds, queue keeps draining
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_instr      instruction word returned combinationally for imem_addr
//   redirect_valid  one-cycle pulse: reload PC from redirect_pc, flush queue
//   redirect_pc     redirect target byte address
//   out_valid       head of fetch queue is valid
//   out_ready       decode accepts the head entry this cycle
//   out_pc          PC of the head entry
//   out_instr       instruction of the head entry
//   fault_misalign  sticky flag: some redirect target was not word aligned
//   fetch_count     number of words pushed into the queue, wraps mod 2^32
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault_misalign,
  output logic [31:0] fetch_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      q_pc    [QUEUE_DEPTH];
  logic [31:0]      q_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[head];
  assign out_instr = q_instr[head];

  // A full queue may still accept a push when the head leaves in the same cycle,
  // which is what sustains one word per cycle. A redirect suppresses the push.
  assign pop  = out_valid & out_ready;
  assign push = (state == RUN) & ~redirect_valid & ((count < DEPTH_CNT) | pop);

  // Run/idle state simply follows fetch_en; a redirect never blocks the transition,
  // so fetching starts from the redirect target on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= fetch_en ? RUN : IDLE;
    end
  end

  // PC, sticky misalignment flag and the pushed-word counter. The redirect target
  // is forced onto a word boundary; the low bits only feed the fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      fault_misalign <= 1'b0;
      fetch_count    <= 32'd0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        fault_misalign <= 1'b1;
      end
    end else if (push) begin
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Circular queue storage. Entries are cleared on reset so the head reads as
  // zero until the first push. On a full queue with push and pop together the
  // tail slot equals the head slot being consumed, so overwriting it is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]    <= 32'd0;
        q_instr[i] <= 32'd0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= pc;
        q_instr[tail] <= imem_instr;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Self-checking bench for fetch_controller. A directed vector table covers the
//   basic fetch, backpressure, redirect and fault behaviour, hand-written sequences
//   cover asynchronous reset, draining with fetch disabled and PC wraparound, and a
//   randomized phase compares the design against a queue-based reference model.
module tb_fetch_controller;

  localparam int QUEUE_DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault_misalign;
  logic [31:0] fetch_count;

  int checks;
  int errors;

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fault_misalign(fault_misalign),
    .fetch_count   (fetch_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h1000 + k.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  assign imem_instr = memWord(imem_addr);

  // Reference model state: queue contents as a list of {pc, instr} pairs.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_count;
  logic        m_run;

  // Directed vector: inputs for one cycle and the outputs expected in that cycle.
  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic        efault;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic modelReset();
    mq.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_count = 32'h0;
    m_run   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs of that cycle.
  task automatic modelStep(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() != 0) && rdy;
    do_push = m_run && !rv && ((mq.size() < QUEUE_DEPTH) || do_pop);
    if (rv) begin
      mq.delete();
      m_pc = rpc & ~32'h3;
      if (rpc[1:0] != 2'b00) m_fault = 1'b1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, instr: memWord(m_pc)});
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end
    m_run = fe;
  endtask

  task automatic compareModel();
    checkOutput("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("fault", {31'd0, fault_misalign}, {31'd0, m_fault});
    checkOutput("fetch_count", fetch_count, m_count);
    if (mq.size() != 0) begin
      checkOutput("out_pc", out_pc, mq[0].pc);
      checkOutput("out_instr", out_instr, mq[0].instr);
    end
  endtask

  // One model-checked cycle, entered and left at posedge+1.
  task automatic runCycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    applyStimulus(fe, rdy, rv, rpc);
    @(negedge clk);
    compareModel();
    @(posedge clk);
    modelStep(fe, rdy, rv, rpc);
    #1;
  endtask

  function automatic vec_t mkVec(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                                 input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                                 input logic [31:0] eaddr, input logic efault, input logic [31:0] ecnt);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr;
    v.eaddr = eaddr; v.efault = efault; v.ecnt = ecnt;
    return v;
  endfunction

  // Hold reset across an edge, release it at a falling edge, resync to posedge+1.
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] frozen_cnt;
    logic [31:0] frozen_addr;
    logic [31:0] rpc;
    checks = 0;
    errors = 0;
    modelReset();

    // Fetch from reset, backpressure, aligned and misaligned redirects, drain
    // with fetch disabled, redirect together with fetch enable.
    vecs[0]  = mkVec(1, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h00, 0, 0);
    vecs[1]  = mkVec(1, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h00, 0, 0);
    vecs[2]  = mkVec(1, 1, 0, 32'h00, 1, 32'h00, 32'h1000, 32'h04, 0, 1);
    vecs[3]  = mkVec(1, 1, 0, 32'h00, 1, 32'h04, 32'h1001, 32'h08, 0, 2);
    vecs[4]  = mkVec(1, 0, 0, 32'h00, 1, 32'h08, 32'h1002, 32'h0C, 0, 3);
    vecs[5]  = mkVec(1, 0, 0, 32'h00, 1, 32'h08, 32'h1002, 32'h10, 0, 4);
    vecs[6]  = mkVec(1, 0, 1, 32'h40, 1, 32'h08, 32'h1002, 32'h10, 0, 4);
    vecs[7]  = mkVec(1, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h40, 0, 4);
    vecs[8]  = mkVec(1, 1, 1, 32'h42, 1, 32'h40, 32'h1010, 32'h44, 0, 5);
    vecs[9]  = mkVec(0, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h40, 1, 5);
    vecs[10] = mkVec(0, 1, 0, 32'h00, 1, 32'h40, 32'h1010, 32'h44, 1, 6);
    vecs[11] = mkVec(0, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h44, 1, 6);
    vecs[12] = mkVec(1, 1, 1, 32'h80, 0, 32'h00, 32'h0000, 32'h44, 1, 6);
    vecs[13] = mkVec(1, 1, 0, 32'h00, 0, 32'h00, 32'h0000, 32'h80, 1, 6);
    vecs[14] = mkVec(1, 1, 0, 32'h00, 1, 32'h80, 32'h1020, 32'h84, 1, 7);

    doReset();
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_out_instr", out_instr, 32'h0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
      checkOutput($sformatf("vec%0d_fault", i), {31'd0, fault_misalign}, {31'd0, vecs[i].efault});
      checkOutput($sformatf("vec%0d_count", i), fetch_count, vecs[i].ecnt);
      if (vecs[i].ev) begin
        checkOutput($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].einstr);
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges must clear outputs with no clock edge.
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_addr", imem_addr, 32'h0);
    checkOutput("async_count", fetch_count, 32'h0);
    checkOutput("async_fault", {31'd0, fault_misalign}, 32'd0);
    doReset();

    // Backpressure from the start: two words queued, PC parked at 8.
    for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_addr", imem_addr, 32'h8);
    checkOutput("bp_head", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Fetch disabled with a full queue: the queue drains, PC and count freeze.
    for (int i = 0; i < 2; i++) runCycle(1'b1, 1'b0, 1'b0, 32'h0);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0);
    frozen_cnt  = m_count;
    frozen_addr = m_pc;
    for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("drain_count_frozen", fetch_count, frozen_cnt);
    checkOutput("drain_addr_frozen", imem_addr, frozen_addr);
    checkOutput("drain_empty", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wraps from the top word to zero without raising a fault.
    runCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    runCycle(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_head", out_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_fault", {31'd0, fault_misalign}, 32'd0);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom();
      if (($urandom() % 4) != 0) rpc[1:0] = 2'b00;
      runCycle(($urandom() % 8) != 0, ($urandom() % 4) != 0, ($urandom() % 16) == 0, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
